// File: rtl/stage_if_fetch_pkg.sv
// Shared definitions for the IF stage: FSM encodings, RV32 constants, reset PC.
// Optional perf counters in the top are enabled by defining IF_PERF_CNT_EN.
package stage_if_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned INST_BYTES       = 4;

    typedef enum logic [3:0] {
        s_INIT = 4'h1,
        s_IF   = 4'h2,
        s_IW   = 4'h4,
        s_DV   = 4'h8
    } if_state_e;

    // Redirect targets may be unaligned; fetch always uses a word address.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/stage_if_fetch_if_pc_next.sv
// Next fetch-PC select: aligned redirect target, sequential successor, or hold.
module if_pc_next
    import stage_if_fetch_pkg::*;
(
    input  logic        redirect,
    input  logic        advance,
    input  logic [31:0] next_pc,
    input  logic [31:0] inst_addr,
    input  logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_nxt
);

    logic [31:0] target;
    logic [31:0] seq_pc;

    assign target = align_pc(next_pc);
    assign seq_pc = inst_addr + 32'(INST_BYTES);

    always_comb begin
        fetch_pc_nxt = fetch_pc;
        if (redirect) begin
            fetch_pc_nxt = target;
        end else if (advance) begin
            fetch_pc_nxt = seq_pc;
        end
    end

endmodule

// File: rtl/stage_if_fetch.sv
// RV32 instruction-fetch stage: memory request/response handshake and delivery to decode.
// Define IF_PERF_CNT_EN to add the If_Wait_Cnt / If_Kill_Cnt performance counters.
//
// state  | meaning
// s_INIT | after reset, load first fetch address
// s_IF   | request presented, waiting for Inst_Req_Ready
// s_IW   | request accepted, waiting for Inst_Valid
// s_DV   | instruction held on Inst_O/PC_O with Done_O high
module stage_if_fetch
    import stage_if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] Inst_Addr,
    output logic        Inst_Req_Valid,
    input  logic        Inst_Req_Ready,
    input  logic [31:0] Instruction,
    input  logic        Inst_Valid,
    output logic        Inst_Ready,
    input  logic [31:0] next_PC,
    input  logic        Feedback_Branch,
    input  logic        Feedback_Mem_Acc,
    output logic [31:0] Inst_O,
    output logic [31:0] PC_O,
    output logic        Done_O
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] If_Wait_Cnt,
    output logic [31:0] If_Kill_Cnt
`endif
);

    if_state_e   state;
    if_state_e   state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_nxt;
    logic        kill;
    logic        kill_nxt;
    logic        redirect;
    logic        kill_eff;
    logic        addr_load;
    logic        resp_take;
    logic        consume;

    // Decode ignores branches while it is stalled on memory, so we do too.
    assign redirect = Feedback_Branch && !Feedback_Mem_Acc;
    assign kill_eff = kill || redirect;

    if_pc_next u_pc_next (
        .redirect     (redirect),
        .advance      (resp_take),
        .next_pc      (next_PC),
        .inst_addr    (Inst_Addr),
        .fetch_pc     (fetch_pc),
        .fetch_pc_nxt (fetch_pc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= s_INIT;
            fetch_pc <= RESET_PC;
            kill     <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            kill     <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        kill_nxt       = kill;
        Inst_Req_Valid = 1'b0;
        Inst_Ready     = 1'b0;
        addr_load      = 1'b0;
        resp_take      = 1'b0;
        consume        = 1'b0;
        unique case (state)
            s_INIT: begin
                addr_load = 1'b1;
                state_nxt = s_IF;
            end
            s_IF: begin
                Inst_Req_Valid = 1'b1;
                if (redirect) begin
                    kill_nxt = 1'b1;
                end
                if (Inst_Req_Ready) begin
                    state_nxt = s_IW;
                end
            end
            s_IW: begin
                Inst_Ready = 1'b1;
                if (redirect) begin
                    kill_nxt = 1'b1;
                end
                if (Inst_Valid) begin
                    // A redirect arriving with the response still kills it.
                    if (kill_eff) begin
                        kill_nxt  = 1'b0;
                        addr_load = 1'b1;
                        state_nxt = s_IF;
                    end else begin
                        resp_take = 1'b1;
                        state_nxt = s_DV;
                    end
                end
            end
            s_DV: begin
                if (!Feedback_Mem_Acc) begin
                    consume   = 1'b1;
                    addr_load = 1'b1;
                    state_nxt = s_IF;
                end
            end
            default: begin
                state_nxt = s_INIT;
            end
        endcase
    end

    // Inst_Addr only moves on entry to s_IF, so it is stable while requesting.
    always_ff @(posedge clk) begin
        if (rst) begin
            Inst_Addr <= RESET_PC;
            Inst_O    <= 32'h0;
            PC_O      <= 32'h0;
            Done_O    <= 1'b0;
        end else begin
            if (addr_load) begin
                Inst_Addr <= fetch_pc_nxt;
            end
            if (resp_take) begin
                Inst_O <= Instruction;
                PC_O   <= Inst_Addr;
                Done_O <= 1'b1;
            end else if (consume) begin
                Done_O <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic waiting;
    logic kill_hit;

    assign waiting  = (state == s_IF) || (state == s_IW);
    assign kill_hit = (state == s_IW) && Inst_Valid && kill_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            If_Wait_Cnt <= 32'h0;
            If_Kill_Cnt <= 32'h0;
        end else begin
            if (waiting) begin
                If_Wait_Cnt <= If_Wait_Cnt + 32'h1;
            end
            if (kill_hit) begin
                If_Kill_Cnt <= If_Kill_Cnt + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stage_if_fetch.sv
// Directed bench for stage_if_fetch with a small instruction-memory responder.
module tb_stage_if_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] Inst_Addr;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] next_PC;
    logic        Feedback_Branch;
    logic        Feedback_Mem_Acc;
    logic [31:0] Inst_O;
    logic [31:0] PC_O;
    logic        Done_O;
`ifdef IF_PERF_CNT_EN
    logic [31:0] If_Wait_Cnt;
    logic [31:0] If_Kill_Cnt;
`endif

    int total = 0;
    int bad   = 0;

    // memory responder controls
    logic mem_on;
    logic late_valid;
    int   mem_delay;

    stage_if_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .Inst_Addr        (Inst_Addr),
        .Inst_Req_Valid   (Inst_Req_Valid),
        .Inst_Req_Ready   (Inst_Req_Ready),
        .Instruction      (Instruction),
        .Inst_Valid       (Inst_Valid),
        .Inst_Ready       (Inst_Ready),
        .next_PC          (next_PC),
        .Feedback_Branch  (Feedback_Branch),
        .Feedback_Mem_Acc (Feedback_Mem_Acc),
        .Inst_O           (Inst_O),
        .PC_O             (PC_O),
        .Done_O           (Done_O)
`ifdef IF_PERF_CNT_EN
        ,
        .If_Wait_Cnt      (If_Wait_Cnt),
        .If_Kill_Cnt      (If_Kill_Cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[21:0], 10'h000};
    endfunction

    // Responder acts just after each rising edge; main stimulus acts on falling edges.
    initial begin
        logic        pend;
        logic [31:0] paddr;
        int          wcnt;
        logic        req_fire;
        logic        resp_fire;
        logic [31:0] req_addr;
        pend = 1'b0; paddr = 32'h0; wcnt = 0;
        req_fire = 1'b0; resp_fire = 1'b0; req_addr = 32'h0;
        Inst_Valid = 1'b0;
        Instruction = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !mem_on) begin
                pend = 1'b0;
            end else begin
                if (resp_fire) pend = 1'b0;
                if (req_fire) begin
                    pend  = 1'b1;
                    paddr = req_addr;
                    wcnt  = mem_delay;
                end else if (pend && wcnt != 0) begin
                    wcnt--;
                end
            end
            Inst_Valid  = mem_on ? (pend && wcnt == 0) : late_valid;
            Instruction = (mem_on && pend) ? inst_of(paddr) : 32'hdead_beef;
            req_fire  = Inst_Req_Valid && Inst_Req_Ready;
            req_addr  = Inst_Addr;
            resp_fire = Inst_Valid && Inst_Ready;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            chk("req_rdy_excl", {31'b0, Inst_Req_Valid && Inst_Ready}, 32'h0);
            if (Done_O) break;
        end
        chk("done_seen", {31'b0, Done_O}, 32'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_done"}, {31'b0, Done_O}, 32'h0);
        chk({tag, "_inst"}, Inst_O, 32'h0);
        chk({tag, "_pc"}, PC_O, 32'h0);
        chk({tag, "_addr"}, Inst_Addr, 32'h0);
        chk({tag, "_reqv"}, {31'b0, Inst_Req_Valid}, 32'h0);
        chk({tag, "_irdy"}, {31'b0, Inst_Ready}, 32'h0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        Inst_Req_Ready = 1'b1;
        Feedback_Branch = 1'b0;
        Feedback_Mem_Acc = 1'b0;
        next_PC = 32'h0;
        mem_on = 1'b1;
        late_valid = 1'b0;
        mem_delay = 0;
        repeat (3) tick();

        // 1: reset state and back-to-back fetch, one delivery every 3 cycles
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();
        chk("t1_first_addr", Inst_Addr, 32'h0);
        chk("t1_first_req", {31'b0, Inst_Req_Valid}, 32'h1);
        wait_done(n);
        chk("t1_lat0", n, 2);
        chk("t1_pc0", PC_O, 32'h0);
        chk("t1_inst0", Inst_O, inst_of(32'h0));
`ifdef IF_PERF_CNT_EN
        chk("t1_wait_cnt", If_Wait_Cnt, 32'd2);
`endif
        wait_done(n);
        chk("t1_lat1", n, 3);
        chk("t1_pc1", PC_O, 32'h4);
        wait_done(n);
        chk("t1_lat2", n, 3);
        chk("t1_pc2", PC_O, 32'h8);
        tick();
        chk("t1_pulse_end", {31'b0, Done_O}, 32'h0);
        chk("t1_next_addr", Inst_Addr, 32'hc);

        // 2: downstream stall holds delivery for 5 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_done(n);
        chk("t2_lat", n, 3);
        chk("t2_inst", Inst_O, 32'h0050_0093);
        Feedback_Mem_Acc = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_hold_done", {31'b0, Done_O}, 32'h1);
            chk("t2_hold_inst", Inst_O, 32'h0050_0093);
            chk("t2_hold_pc", PC_O, 32'h0);
            chk("t2_hold_noreq", {31'b0, Inst_Req_Valid}, 32'h0);
        end
        Feedback_Mem_Acc = 1'b0;
        tick();
        chk("t2_rel_done", {31'b0, Done_O}, 32'h0);
        chk("t2_rel_req", {31'b0, Inst_Req_Valid}, 32'h1);
        chk("t2_rel_addr", Inst_Addr, 32'h4);
        wait_done(n);
        chk("t2_next_pc", PC_O, 32'h4);

        // 3: branch in s_DV at 0x20 to unaligned 0x1003
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) wait_done(n);
        chk("t3_at_pc", PC_O, 32'h20);
        Feedback_Branch = 1'b1;
        next_PC = 32'h0000_1003;
        tick();
        Feedback_Branch = 1'b0;
        chk("t3_redir_addr", Inst_Addr, 32'h1000);
        chk("t3_redir_req", {31'b0, Inst_Req_Valid}, 32'h1);
        chk("t3_redir_done", {31'b0, Done_O}, 32'h0);
        wait_done(n);
        chk("t3_lat", n, 2);
        chk("t3_pc", PC_O, 32'h1000);
        chk("t3_inst", Inst_O, inst_of(32'h1000));

        // 4: redirect while waiting on a slow response for 0x40
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) wait_done(n);
        chk("t4_at_pc", PC_O, 32'h3c);
        mem_delay = 4;
        tick();
        chk("t4_req_addr", Inst_Addr, 32'h40);
        tick();
        chk("t4_in_iw", {31'b0, Inst_Ready}, 32'h1);
        Feedback_Branch = 1'b1;
        next_PC = 32'h200;
        for (int k = 0; k < 4; k++) begin
            tick();
            Feedback_Branch = 1'b0;
            chk("t4_no_done", {31'b0, Done_O}, 32'h0);
            chk("t4_still_iw", {31'b0, Inst_Ready}, 32'h1);
        end
        tick();
        chk("t4_kill_done", {31'b0, Done_O}, 32'h0);
        chk("t4_new_addr", Inst_Addr, 32'h200);
        chk("t4_new_req", {31'b0, Inst_Req_Valid}, 32'h1);
`ifdef IF_PERF_CNT_EN
        chk("t4_kill_cnt", If_Kill_Cnt, 32'd1);
`endif
        mem_delay = 0;
        wait_done(n);
        chk("t4_pc", PC_O, 32'h200);

        // 5: branch ignored while stalled
        Feedback_Branch = 1'b1;
        Feedback_Mem_Acc = 1'b1;
        next_PC = 32'h800;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t5_hold_done", {31'b0, Done_O}, 32'h1);
            chk("t5_hold_pc", PC_O, 32'h200);
        end
        Feedback_Branch = 1'b0;
        Feedback_Mem_Acc = 1'b0;
        tick();
        chk("t5_seq_addr", Inst_Addr, 32'h204);
        chk("t5_rel_done", {31'b0, Done_O}, 32'h0);
        wait_done(n);
        chk("t5_pc", PC_O, 32'h204);

        // 6: reset while in s_IW, late response after reset is ignored
        mem_on = 1'b0;
        tick();
        chk("t6_req_addr", Inst_Addr, 32'h208);
        tick();
        chk("t6_in_iw", {31'b0, Inst_Ready}, 32'h1);
        rst = 1'b1;
        late_valid = 1'b1;
        tick();
        check_reset_outputs("t6_rst");
        rst = 1'b0;
        tick();
        chk("t6_late_valid", {31'b0, Inst_Valid}, 32'h1);
        chk("t6_irdy", {31'b0, Inst_Ready}, 32'h0);
        chk("t6_req", {31'b0, Inst_Req_Valid}, 32'h1);
        chk("t6_addr", Inst_Addr, 32'h0);
        chk("t6_done", {31'b0, Done_O}, 32'h0);
        late_valid = 1'b0;
        mem_on = 1'b1;
        wait_done(n);
        chk("t6_lat", n, 2);
        chk("t6_pc", PC_O, 32'h0);
        chk("t6_inst", Inst_O, inst_of(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
